// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: scans the synchronized held-key mask one key per
// cycle and maps presses/releases onto NVOICES oscillator voices, stealing the oldest.
module voice_alloc #(
    parameter int NVOICES = 4,
    parameter int NKEYS   = 12
) (
    input  logic                 clk,
    input  logic                 ar,
    input  logic [NKEYS-1:0]     key_mask,
    output logic [4*NVOICES-1:0] voice_key,
    output logic [NVOICES-1:0]   voice_gate,
    output logic [NVOICES-1:0]   voice_start,
    output logic                 steal,
    output logic                 busy
);

    localparam int AW = $clog2(NVOICES);
    localparam int IW = (NKEYS > 1) ? $clog2(NKEYS) : 1;

    // busy mirrors the FSM state one-to-one (high exactly while in SCAN).
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t            state;
    logic [NKEYS-1:0]  sync1;
    logic [NKEYS-1:0]  sync2;
    logic [NKEYS-1:0]  snap;
    logic [NKEYS-1:0]  seen;
    logic [IW-1:0]     idx;
    logic [AW-1:0]     age [NVOICES];

    logic              rel_hit;
    logic [AW-1:0]     rel_v;
    logic              free_hit;
    logic [AW-1:0]     free_v;
    logic [AW-1:0]     old_v;
    logic [AW-1:0]     tgt;
    logic [AW-1:0]     tgt_age;
    logic              do_press;
    logic              do_release;

    // Voice lookups for the key under the scan pointer.
    always_comb begin
        rel_hit  = 1'b0;
        rel_v    = '0;
        free_hit = 1'b0;
        free_v   = '0;
        old_v    = '0;
        for (int v = 0; v < NVOICES; v++) begin
            if (!rel_hit && voice_gate[v] && (voice_key[4*v +: 4] == 4'(idx))) begin
                rel_hit = 1'b1;
                rel_v   = AW'(v);
            end
            if (!free_hit && !voice_gate[v]) begin
                free_hit = 1'b1;
                free_v   = AW'(v);
            end
            if (age[v] == '0) begin
                old_v = AW'(v);
            end
        end
        tgt        = free_hit ? free_v : old_v;
        tgt_age    = age[tgt];
        do_press   = (state == SCAN) && snap[idx] && !seen[idx];
        do_release = (state == SCAN) && !snap[idx] && seen[idx];
    end

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            state       <= IDLE;
            sync1       <= '0;
            sync2       <= '0;
            snap        <= '0;
            seen        <= '0;
            idx         <= '0;
            voice_key   <= '0;
            voice_gate  <= '0;
            voice_start <= '0;
            steal       <= 1'b0;
            busy        <= 1'b0;
            for (int v = 0; v < NVOICES; v++) begin
                age[v] <= AW'(v);
            end
        end else begin
            sync1       <= key_mask;
            sync2       <= sync1;
            voice_start <= '0;
            steal       <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync2 != seen) begin
                        snap  <= sync2;
                        idx   <= '0;
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (do_release) begin
                        seen[idx] <= 1'b0;
                    end else if (do_press) begin
                        seen[idx] <= 1'b1;
                        steal     <= !free_hit;
                    end
                    // A release of a stolen key finds no gated voice and only clears seen.
                    for (int v = 0; v < NVOICES; v++) begin
                        if (do_release && rel_hit && (AW'(v) == rel_v)) begin
                            voice_gate[v] <= 1'b0;
                        end
                        if (do_press) begin
                            if (AW'(v) == tgt) begin
                                voice_key[4*v +: 4] <= 4'(idx);
                                voice_gate[v]       <= 1'b1;
                                voice_start[v]      <= 1'b1;
                                age[v]              <= AW'(NVOICES - 1);
                            end else if (age[v] > tgt_age) begin
                                age[v] <= age[v] - 1'b1;
                            end
                        end
                    end
                    if (idx == IW'(NKEYS - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc: timed checks after each scan edge plus a
// scoreboard of expected {steal, voice, key} allocation events.
module tb_voice_alloc;

    localparam int NV = 4;
    localparam int NK = 12;

    logic          clk = 1'b0;
    logic          ar;
    logic [NK-1:0] key_mask;
    logic [4*NV-1:0] voice_key;
    logic [NV-1:0] voice_gate;
    logic [NV-1:0] voice_start;
    logic          steal;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int ecount = 0;
    int e_base = 0;
    logic [7:0] exp_q[$];

    voice_alloc #(.NVOICES(NV), .NKEYS(NK)) dut (
        .clk        (clk),
        .ar         (ar),
        .key_mask   (key_mask),
        .voice_key  (voice_key),
        .voice_gate (voice_gate),
        .voice_start(voice_start),
        .steal      (steal),
        .busy       (busy)
    );

    // Clock, edge counter and watchdog.
    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ev(input logic s, input int v, input int k);
        return {s, 3'(v), 4'(k)};
    endfunction

    // Drives a new mask just after an edge; the following edge is E0.
    task automatic set_mask(input logic [NK-1:0] m);
        @(posedge clk);
        #1;
        key_mask = m;
        e_base   = ecount;
    endtask

    // Returns 1 time unit after edge En of the current mask change.
    task automatic wait_after(input int n);
        while (ecount < e_base + 1 + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every start pulse must match the oldest expected allocation.
    always @(negedge clk) begin : monitor
        logic [7:0] got;
        logic [7:0] want;
        if (ar === 1'b1 && voice_start !== '0) begin
            for (int v = 0; v < NV; v++) begin
                if (voice_start[v]) begin
                    got  = {steal, 3'(v), voice_key[4*v +: 4]};
                    want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
                    chk("alloc_event", got, want);
                end
            end
        end
    end

    initial begin
        int n;
        ar       = 1'b0;
        key_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gate", voice_gate, 0);
        chk("rst_busy", busy, 0);
        chk("rst_key", voice_key, 0);
        chk("rst_start", voice_start, 0);
        chk("rst_steal", steal, 0);
        ar = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);

        // Single note: key 3 lands on voice 0 at E6.
        set_mask(12'h008);
        exp_q.push_back(ev(1'b0, 0, 3));
        wait_after(1);  chk("single_busy_e1", busy, 0);
        wait_after(2);  chk("single_busy_e2", busy, 1);
        wait_after(5);  chk("single_gate_e5", voice_gate, 4'h0);
        wait_after(6);  chk("single_gate_e6", voice_gate, 4'h1);
        chk("single_start_e6", voice_start, 4'h1);
        chk("single_key_e6", voice_key[3:0], 3);
        wait_after(7);  chk("single_start_e7", voice_start, 4'h0);
        wait_after(13); chk("single_busy_e13", busy, 1);
        wait_after(14); chk("single_busy_e14", busy, 0);
        set_mask(12'h000);
        wait_after(5);  chk("single_rel_e5", voice_gate, 4'h1);
        wait_after(6);  chk("single_rel_e6", voice_gate, 4'h0);
        chk("single_rel_key", voice_key[3:0], 3);
        wait_after(15);

        // Chord 0,5,7 in one step.
        set_mask(12'h0A1);
        exp_q.push_back(ev(1'b0, 0, 0));
        exp_q.push_back(ev(1'b0, 1, 5));
        exp_q.push_back(ev(1'b0, 2, 7));
        n = 0;
        for (int i = 0; i < 20; i++) begin
            wait_after(i);
            if (busy === 1'b1) n++;
            if (i == 3)  chk("chord_gate_e3", voice_gate, 4'h1);
            if (i == 8)  chk("chord_gate_e8", voice_gate, 4'h3);
            if (i == 10) chk("chord_gate_e10", voice_gate, 4'h7);
        end
        chk("chord_busy_cycles", n, 12);
        chk("chord_keys", voice_key, 16'h0750);
        set_mask(12'h000);
        wait_after(15);
        chk("chord_rel_gate", voice_gate, 4'h0);
        chk("chord_rel_keys", voice_key, 16'h0750);

        // Steal: keys 0..3 in separate scans, then key 4 takes voice 0.
        for (int k = 0; k < 4; k++) begin
            set_mask(12'((1 << (k + 1)) - 1));
            exp_q.push_back(ev(1'b0, k, k));
            wait_after(15);
        end
        chk("steal_pre_gate", voice_gate, 4'hF);
        chk("steal_pre_keys", voice_key, 16'h3210);
        set_mask(12'h01F);
        exp_q.push_back(ev(1'b1, 0, 4));
        wait_after(6);  chk("steal_e6", steal, 0);
        wait_after(7);  chk("steal_e7", steal, 1);
        chk("steal_start_e7", voice_start, 4'h1);
        wait_after(8);  chk("steal_e8", steal, 0);
        wait_after(15); chk("steal_keys", voice_key, 16'h3214);
        chk("steal_gate", voice_gate, 4'hF);
        set_mask(12'h01E);
        wait_after(3);  chk("stolen_rel_e3", voice_gate, 4'hF);
        wait_after(15); chk("stolen_rel_end", voice_gate, 4'hF);
        set_mask(12'h000);
        wait_after(15); chk("steal_clear", voice_gate, 4'h0);

        // Same-scan release of key 4 frees voice 0 for key 8.
        set_mask(12'h0F0);
        for (int k = 0; k < 4; k++) exp_q.push_back(ev(1'b0, k, k + 4));
        wait_after(15);
        chk("full_gate", voice_gate, 4'hF);
        chk("full_keys", voice_key, 16'h7654);
        set_mask(12'h1E0);
        exp_q.push_back(ev(1'b0, 0, 8));
        wait_after(6);  chk("relpress_e6", voice_gate, 4'hF);
        wait_after(7);  chk("relpress_e7", voice_gate, 4'hE);
        wait_after(10); chk("relpress_e10", voice_gate, 4'hE);
        wait_after(11); chk("relpress_e11", voice_gate, 4'hF);
        chk("relpress_steal", steal, 0);
        wait_after(15); chk("relpress_keys", voice_key, 16'h7658);
        set_mask(12'h000);
        wait_after(15); chk("relpress_clear", voice_gate, 4'h0);

        // Key 9 pressed after the scan pointer passed it waits for the next scan.
        set_mask(12'h001);
        exp_q.push_back(ev(1'b0, 0, 0));
        exp_q.push_back(ev(1'b0, 1, 9));
        wait_after(12);
        key_mask = 12'h201;
        wait_after(14); chk("late_gate_e14", voice_gate, 4'h1);
        chk("late_busy_e14", busy, 0);
        wait_after(15); chk("late_busy_e15", busy, 1);
        wait_after(24); chk("late_gate_e24", voice_gate, 4'h1);
        wait_after(25); chk("late_gate_e25", voice_gate, 4'h3);
        chk("late_keys", voice_key, 16'h7690);
        wait_after(28);

        // Asynchronous reset in the middle of a scan.
        set_mask(12'h0F1);
        wait_after(5);
        chk("mid_busy", busy, 1);
        chk("mid_gate", voice_gate, 4'h3);
        ar = 1'b0;
        #1;
        chk("arst_gate", voice_gate, 0);
        chk("arst_busy", busy, 0);
        chk("arst_keys", voice_key, 0);
        key_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        ar = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_gate", voice_gate, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
